// File: rtl/ip_dram_pkg.sv
// ip_dram_pkg: shared state encoding, requester ids and address layout for the DDR3 arbiter
package ip_dram_pkg;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int BANK_LSB = 24;
  localparam int ROW_LSB = 10;
  localparam int COL_LSB = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  typedef enum logic {REQ_A, REQ_B} req_t;
  function automatic logic [2:0] addr_bank(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:BANK_LSB];
  endfunction
  function automatic logic [13:0] addr_row(input logic [ADDR_W-1:0] a);
    return a[BANK_LSB-1:ROW_LSB];
  endfunction
endpackage

// File: rtl/ip_dram_rr_select.sv
// ip_dram_rr_select: two-way requester picker, round-robin or fixed A priority
module ip_dram_rr_select import ip_dram_pkg::*; #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic en,
  output logic pick_b,
  output logic any
);
  req_t last_grant;
  assign any = a_valid | b_valid;
  // on a tie B wins only when round-robin is on and A had the last grant
  assign pick_b = b_valid & (~a_valid | (~FIXED_PRIORITY & (last_grant == REQ_A)));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= REQ_B;
    else if (en && any) last_grant <= pick_b ? REQ_B : REQ_A;
endmodule

// File: rtl/ip_dram_arbiter.sv
// ip_dram_arbiter: shares one DDR3 controller user port between requesters A and B,
// one transaction in flight, read data routed back to the requester that issued it.
module ip_dram_arbiter import ip_dram_pkg::*; #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sdram_init_busy,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_write,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [MASK_W-1:0] a_wdata_mask,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rdata_valid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_write,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [MASK_W-1:0] b_wdata_mask,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rdata_valid,
  output logic [ADDR_W-1:0] dram_address,
  output logic              dram_write,
  output logic              dram_valid,
  output logic [DATA_W-1:0] dram_wdata,
  output logic [MASK_W-1:0] dram_wdata_mask,
  input  logic              dram_ready,
  input  logic [DATA_W-1:0] dram_rdata,
  input  logic              dram_rdata_valid
);
  state_t state;
  req_t   owner;
  logic   pick_b, any, grant;
  ip_dram_rr_select #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_sel (
    .clk     (clk),
    .reset_n (reset_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .en      ((state == IDLE) && !sdram_init_busy),
    .pick_b  (pick_b),
    .any     (any)
  );
  assign grant = (state == IDLE) && !sdram_init_busy && any;
  assign a_rdata = dram_rdata;
  assign b_rdata = dram_rdata;
  assign a_rdata_valid = (state == WAIT_RD) && (owner == REQ_A) && dram_rdata_valid;
  assign b_rdata_valid = (state == WAIT_RD) && (owner == REQ_B) && dram_rdata_valid;
  // ready pulses in the cycle after the grant edge; dram_valid rises one cycle later
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      owner <= REQ_A;
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      dram_valid <= 1'b0;
      dram_address <= '0;
      dram_write <= 1'b0;
      dram_wdata <= '0;
      dram_wdata_mask <= '0;
    end else begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          a_ready <= ~pick_b;
          b_ready <= pick_b;
          owner <= pick_b ? REQ_B : REQ_A;
          dram_address <= pick_b ? b_address : a_address;
          dram_write <= pick_b ? b_write : a_write;
          dram_wdata <= pick_b ? b_wdata : a_wdata;
          dram_wdata_mask <= pick_b ? b_wdata_mask : a_wdata_mask;
          state <= ISSUE;
        end
        ISSUE: if (!dram_valid) dram_valid <= 1'b1;
        else if (dram_ready) begin
          dram_valid <= 1'b0;
          state <= dram_write ? IDLE : WAIT_RD;
        end
        WAIT_RD: if (dram_rdata_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/ip_dram_arbiter.md
IP_DRAM_ARBITER -- requirements
Module: ip_dram_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0: 0 = round-robin between requesters; 1 = requester A always wins ties.
REQ-002 clk  input  1  single clock domain (74.25MHz DDR3 controller user clock).
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 sdram_init_busy  input  1  1 = DDR3 controller initialising; no grants issued.
REQ-005 a_/b_address  input  27  requester word address: [26:24] bank, [23:10] row, [9:0] column.
REQ-006 a_/b_write  input  1  0 = read, 1 = write.
REQ-007 a_/b_valid  input  1  request present; requester holds all request fields stable until ready.
REQ-008 a_/b_ready  output  1  one-cycle pulse; the request is accepted in that cycle.
REQ-009 a_/b_wdata  input  128  write data.
REQ-010 a_/b_wdata_mask  input  16  byte mask; 1 = byte not written.
REQ-011 a_/b_rdata  output  128  read data, copy of dram_rdata.
REQ-012 a_/b_rdata_valid  output  1  read data strobe for that requester only.
REQ-013 dram_address, dram_write, dram_valid, dram_wdata, dram_wdata_mask  output  27/1/1/128/16  request to the DDR3 controller.
REQ-014 dram_ready  input  1  controller accepts the request when dram_valid and dram_ready are both 1.
REQ-015 dram_rdata  input  128  controller read data.
REQ-016 dram_rdata_valid  input  1  controller read strobe.

Function
REQ-017 States: IDLE, ISSUE, WAIT_RD; exactly one transaction in flight at any time.
REQ-018 IDLE, sdram_init_busy=0, at least one valid: grant one requester, pulse its ready, latch its fields into the dram_* registers, set owner, go to ISSUE.
REQ-019 IDLE with sdram_init_busy=1: both ready outputs stay 0 and the state stays IDLE.
REQ-020 Tie-break with FIXED_PRIORITY=0: grant the requester not granted last; with FIXED_PRIORITY=1: grant A. A single valid requester is always granted.
REQ-021 Latency: a request accepted in cycle N drives dram_valid=1 in cycle N+1.
REQ-022 ISSUE: hold dram_valid and all dram_* fields until dram_ready=1. On acceptance: write goes to IDLE; read goes to WAIT_RD. dram_valid falls in the next cycle.
REQ-023 WAIT_RD: on dram_rdata_valid, the owner's rdata_valid=1 combinationally in the same cycle, then go to IDLE; the other requester's rdata_valid stays 0.
REQ-024 a_rdata and b_rdata equal dram_rdata at all times.
REQ-025 dram_rdata_valid outside WAIT_RD is ignored; no rdata_valid output is raised.
REQ-026 No new grant is issued in the same cycle a transaction completes. A grant requires IDLE at the clock edge, giving a minimum 1-cycle IDLE gap.
REQ-027 The round-robin pointer is updated only on a grant.

Reset
REQ-028 When reset_n=0: state=IDLE, dram_valid=0, a/b_ready=0, a/b_rdata_valid=0, dram_address=0, dram_write=0, dram_wdata=0, dram_wdata_mask=0, owner=A, last_grant=B.
REQ-029 Reset asserted mid-transaction abandons the transaction; any later dram_rdata_valid is ignored per REQ-025.

Structure
REQ-030 State encodings and the 27-bit address split constants belong in the shared package ip_dram_pkg.
REQ-031 One sub-module is used: ip_dram_rr_select (2-way round-robin/fixed priority picker, combinational pick plus last_grant register).

Verification
REQ-032 Initialisation hold: sdram_init_busy=1 with a_valid=1 for 20 cycles -> no a_ready and dram_valid=0; release busy -> a_ready pulses next cycle and dram_valid follows 1 cycle later.
REQ-033 Write pass-through: A writes address 0x0000010, wdata 0x0123...EF, mask 0x0000 -> dram_* carry those exact values; dram_ready delayed 5 cycles -> fields held stable, dram_valid drops after acceptance.
REQ-034 Read routing: B reads 0x1000400; controller returns data 0xDEADBEEF... after 12 cycles -> b_rdata_valid=1 for 1 cycle with that data, a_rdata_valid=0.
REQ-035 Round-robin: A and B both valid continuously for 6 writes -> grants alternate A,B,A,B,A,B. With FIXED_PRIORITY=1 -> all A while a_valid=1.
REQ-036 Stray strobe and reset: dram_rdata_valid in IDLE -> no rdata_valid. Reset asserted in WAIT_RD -> outputs return to REQ-028 values asynchronously; a subsequent strobe is ignored.
